serial_mult3: RTL and testbench
===============================

# serial_mult3

Sequential 3×3-bit unsigned shift-and-add multiplier that produces a 6-bit product using a single `fulladder` instance as a bit-serial adder.
It sits directly upstream of the full-adder datapath, sequencing operand and partial-product bits through the adder and collecting its outputs.
It is the area-minimal counterpart of the parallel 3-bit multiplier: one adder and fixed 12-cycle latency, in exchange for the adder array.

## Interface
Parameters:
- none — operand width fixed at 3, product width 6.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled on a rising edge in IDLE or DONE only.
- `A`  in  3  multiplicand; latched when `start` is accepted.
- `B`  in  3  multiplier; latched when `start` is accepted.
- `Product`  out  6  A×B; registered, valid while `done`=1, held until the next accepted `start`.
- `busy`  out  1  high while in CALC.
- `done`  out  1  high for exactly one cycle (state DONE).

## Operation
- Registers:
  - `a_r[2:0]`, `b_r[2:0]`: latched operands.
  - `acc[5:0]`: accumulator, drives `Product`.
  - `cy`: carry flop.
  - `i[1:0]`: iteration, 0..2.
  - `j[1:0]`: bit step, 0..3.
- FSM:
  - IDLE: `start` → CALC. On that edge: `a_r`←A, `b_r`←B, `acc`←0, `cy`←0, `i`←0, `j`←0.
  - CALC: one full-adder step per cycle.
    - Adder inputs: A_in = `acc[i+j]`, B_in = pp[j], Carry_in = `cy`.
    - Partial product: pp[j] = `a_r[j]` & `b_r[i]` for j<3, and pp[3] = 0.
    - Each edge: `acc[i+j]`←Sum, `cy`←Carry_out.
    - When j=3: j←0, cy←0, i←i+1.
    - After step (i=2, j=3), go to DONE.
  - DONE: `done`=1. If `start`=1 → CALC, with the same loads as from IDLE (back-to-back). Otherwise → IDLE.
- Arithmetic:
  - Before iteration i, `acc` < 8·2^i. Adding pp·2^i (≤ 7·2^i) gives a result < 16·2^i, so it always fits in bits i..i+3.
  - Carry_out at j=3 is therefore always 0. The bench asserts this; the RTL discards it.
- Every iteration runs all 4 steps, including when `b_r[i]`=0. There is no early exit, so latency is fixed.
- `start` while in CALC is ignored. A and B changes during CALC have no effect.
- Reset (any time, including mid-CALC): state←IDLE.
  - `acc`, `a_r`, `b_r`, `cy`, `i`, `j` ← 0.
  - `Product`=0, `busy`=0, `done`=0.
  - The computation in progress is abandoned and produces no `done`.

## Timing
- `start` accepted at edge k:
  - State is CALC for cycles k..k+11, with `busy`=1.
  - Steps execute on edges k+1..k+12.
  - DONE is entered at edge k+12: `done`=1 and `Product` is final from edge k+12.
- Latency: 12 clocks from the accepting edge to `done`.
- Minimum throughput (back-to-back): 13 cycles per product.
- `Product` mirrors `acc` continuously, so it shows intermediate values during CALC. Consumers sample it only when `done`=1.
- All outputs are registered or pure state decodes; there is no combinational path from inputs to outputs.

## Structure
- Shared package `mult3_pkg` holds:
  - `OP_W`=3, `PROD_W`=6, `STEPS_PER_ITER`=4, `N_ITER`=3.
  - `state_t` {IDLE, CALC, DONE}.
- Sub-module: one instance of the existing `fulladder`. It is combinational; `serial_mult3` owns the carry flop.
- All control logic (FSM, counters, bit select/insert) is in `serial_mult3`.

## Test plan
- Reset, then A=7, B=7, `start` for 1 cycle → `busy`=1 for 12 cycles, then `done` pulses once with `Product`=49 (6'b110001); `Product` holds 49 in IDLE.
- A=0, B=5 → `Product`=0 at `done`. Then A=5, B=3 → 15. Then A=6, B=7 → 42. Latency is 12 in every case.
- Exhaustive 64 operand pairs, including back-to-back: `start` held high in DONE → every result equals A×B; period 13 cycles; the j=3 carry assertion never fires.
- `start` pulsed mid-CALC with different A/B → ignored; result reflects the originally latched operands.
- `rst_n` low during step 6 of A=7, B=5 → asynchronously `Product`=0, `busy`=0, `done`=0. After release, no `done` occurs until a new `start`, whose result is correct.
- A/B toggled randomly every cycle during CALC → `Product` unaffected.

Source files
------------

// File: rtl/mult3_pkg.sv
// rtl/mult3_pkg.sv - shared widths and state encoding for the serial 3x3 multiplier
package mult3_pkg;
  localparam int OP_W           = 3;
  localparam int PROD_W         = 6;
  localparam int STEPS_PER_ITER = 4;
  localparam int N_ITER         = 3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - combinational one-bit full adder
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Carry_in,
  output logic Sum,
  output logic Carry_out
);
  assign Sum       = A ^ B ^ Carry_in;
  assign Carry_out = (A & B) | (Carry_in & (A ^ B));
endmodule

// File: rtl/serial_mult3.sv
// rtl/serial_mult3.sv - bit-serial 3x3 shift-and-add multiplier around a single full adder
module serial_mult3
  import mult3_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] Product,
  output logic              busy,
  output logic              done
);
  state_t r_state, w_state_nxt;

  logic [OP_W-1:0]   r_a, r_b;
  logic [PROD_W-1:0] r_acc;
  logic              r_cy;
  logic [1:0]        r_i, r_j;

  logic [2:0] w_idx;
  logic       w_last_step, w_last_iter, w_accept;
  logic       w_pp, w_sum, w_cout;

  assign w_idx       = {1'b0, r_i} + {1'b0, r_j};
  assign w_last_step = (r_j == 2'(STEPS_PER_ITER - 1));
  assign w_last_iter = (r_i == 2'(N_ITER - 1));
  assign w_accept    = start && (r_state != CALC);
  // Step j=3 only ripples the carry into bit i+3.
  assign w_pp        = w_last_step ? 1'b0 : (r_a[r_j] & r_b[r_i]);

  fulladder u_fa (
    .A         (r_acc[w_idx]),
    .B         (w_pp),
    .Carry_in  (r_cy),
    .Sum       (w_sum),
    .Carry_out (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (w_last_step && w_last_iter) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cy  <= 1'b0;
      r_i   <= '0;
      r_j   <= '0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_acc <= '0;
      r_cy  <= 1'b0;
      r_i   <= '0;
      r_j   <= '0;
    end else if (r_state == CALC) begin
      r_acc[w_idx] <= w_sum;
      if (w_last_step) begin
        // The carry out of bit i+3 is provably zero, so it is dropped here.
        r_j  <= '0;
        r_cy <= 1'b0;
        r_i  <= w_last_iter ? 2'd0 : r_i + 2'd1;
      end else begin
        r_j  <= r_j + 2'd1;
        r_cy <= w_cout;
      end
    end
  end

  assign Product = r_acc;
  assign busy    = (r_state == CALC);
  assign done    = (r_state == DONE);
endmodule

// File: tb/tb_serial_mult3.sv
// tb/tb_serial_mult3.sv - scoreboard bench for serial_mult3 with randomized operands
module tb_serial_mult3;
  import mult3_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] A = '0, B = '0;
  logic [5:0] Product;
  logic       busy, done;

  serial_mult3 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .Product(Product), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int prod; int due; } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int m_done_edge = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a request is taken whenever the previous job has finished,
  // and its answer is due exactly 12 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_done_edge = -1;
    end else begin
      cyc++;
      if (start && cyc > m_done_edge) begin
        q.push_back('{prod: int'(A) * int'(B), due: cyc + 12});
        m_done_edge = cyc + 12;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", int'(busy), int'(cyc < m_done_edge));
      if (busy && dut.r_j == 2'd3 && dut.w_cout) begin
        n_err++;
        $display("FAIL carry_j3: carry out 1 at step j=3, expected 0 (edge %0d)", cyc);
      end
      if (done) begin
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_done: done=1 with nothing outstanding (edge %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", int'(Product), e.prod);
          chk("latency_edge", cyc, e.due);
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("done_timeout", 0, 1);
      end
    end
  end

  task automatic run(input int a, input int b);
    int n;
    @(negedge clk);
    A = 3'(a); B = 3'(b); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      A = 3'($urandom); B = 3'($urandom);
      n++;
    end
    if (!done) chk("run_wait_done", 0, 1);
    repeat (3) @(negedge clk);
    chk("hold_product", int'(Product), a * b);
    chk("idle_done", int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_product", int'(Product), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(7, 7);
    run(0, 5);
    run(5, 3);
    run(6, 7);

    // Exhaustive back-to-back with start held high and operands scrambled during CALC.
    for (int p = 0; p < 64; p++) begin
      @(negedge clk);
      A = 3'(p >> 3); B = 3'(p); start = 1'b1;
      @(posedge clk);
      repeat (12) begin
        @(negedge clk);
        A = 3'($urandom); B = 3'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_drained", q.size(), 0);

    // Mid-CALC start pulse with different operands must be ignored.
    @(negedge clk);
    A = 3'd3; B = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    A = 3'd7; B = 3'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignored_start_product", int'(Product), 18);

    // Asynchronous reset during step 6 of 7x5.
    @(negedge clk);
    A = 3'd7; B = 3'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_product", int'(Product), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", int'(done), 0);
    run(7, 5);

    for (int k = 0; k < 10; k++) run(int'($urandom_range(7)), int'($urandom_range(7)));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
